// File: rtl/sdram_linefetch.sv
// Sequential read prefetcher: issues one-at-a-time word reads to the SDRAM
// controller and buffers the returned words in a show-ahead FIFO.
module sdram_linefetch #(
  parameter int XWIDTH  = 20,
  parameter int DWIDTH  = 16,
  parameter int LENBITS = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [XWIDTH-1:0]  base_addr,
  input  logic [LENBITS-1:0] length,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [DWIDTH-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XWIDTH-1:0]  mem_rd_addr,
  output logic               mem_rd_req,
  input  logic [DWIDTH-1:0]  mem_rd_data,
  input  logic               mem_rd_valid
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]         state;
  logic [XWIDTH-1:0]  addr;
  logic [LENBITS-1:0] remaining;

  logic [DWIDTH-1:0]  fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic push;
  logic pop;
  logic flush;
  logic fifo_full;

  // Occupancy never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign fifo_full = count[FIFO_AW];
  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];

  always_comb begin
    push  = (state == S_WAIT) && mem_rd_valid && !abort;
    pop   = out_valid && out_ready;
    flush = (((state == S_IDLE) || (state == S_RUN)) && abort) ||
            (((state == S_WAIT) && abort) || (state == S_DRAIN)) && mem_rd_valid;
  end

  // NOTE: storage has no reset; out_valid gates it, and a reset would force flops instead of RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (length != '0) begin
              addr      <= base_addr;
              remaining <= length;
              busy      <= 1'b1;
              state     <= S_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if ((remaining != '0) && !fifo_full) begin
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= addr;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            mem_rd_req <= 1'b0;
            if (abort) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              addr      <= addr + XWIDTH'(1);
              remaining <= remaining - LENBITS'(1);
              if (remaining == LENBITS'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_RUN;
              end
            end
          end else if (abort) begin
            // The controller cannot cancel a read; keep requesting until it returns.
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_rd_valid) begin
            mem_rd_req <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_linefetch.sv
// Bench for sdram_linefetch: table-driven transfers plus hand-written abort,
// backpressure, reset and random out_ready sequences against a memory model.
module tb_sdram_linefetch;
  localparam int XW  = 20;
  localparam int DW  = 16;
  localparam int LB  = 16;
  localparam int FAW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] base_addr = '0;
  logic [LB-1:0] length = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [XW-1:0] mem_rd_addr;
  logic          mem_rd_req;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_valid = 1'b0;

  sdram_linefetch #(.XWIDTH(XW), .DWIDTH(DW), .LENBITS(LB), .FIFO_AW(FAW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .busy(busy), .done(done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_req(mem_rd_req),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected read addresses and delivered words, filled when a transfer starts.
  logic [XW-1:0] addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  int            lat_cfg = 5;   // 0 selects a random latency of 1..4
  int            ready_pct = 100;
  bit            pending = 1'b0;
  bit            orphan = 1'b0;
  int            cnt = 0;
  logic [XW-1:0] cur = '0;
  logic [XW-1:0] last_issue = '0;
  int            reads = 0;
  int            done_cnt = 0;
  int            delivered = 0;

  // Controller model: one read at a time, data = address ^ 0xA5A5.
  initial forever begin
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;
    mem_rd_data  = DW'($urandom);
    if (!rst_n) orphan = 1'b1;
    if (pending) begin
      if (!orphan) begin
        check("req_hold", 32'(mem_rd_req), 32'd1);
        check("addr_hold", 32'(mem_rd_addr), 32'(cur));
      end
      cnt--;
      if (cnt <= 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = cur[DW-1:0] ^ 16'hA5A5;
        pending      = 1'b0;
      end
    end else if (rst_n && mem_rd_req) begin
      pending    = 1'b1;
      orphan     = 1'b0;
      cnt        = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
      cur        = mem_rd_addr;
      last_issue = mem_rd_addr;
      reads++;
      check("read_expected", 32'(addr_q.size() != 0), 32'd1);
      if (addr_q.size() != 0) check("read_addr", 32'(mem_rd_addr), 32'(addr_q.pop_front()));
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = (int'($urandom_range(99)) < ready_pct);
  end

  // Consumer and done monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      delivered++;
      got_q.push_back(out_data);
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  int reads0, done0, del0, got0;

  task automatic start_xfer(input logic [XW-1:0] base, input int len);
    logic [XW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + XW'(i);
      addr_q.push_back(a);
      exp_q.push_back(a[DW-1:0] ^ 16'hA5A5);
    end
    reads0 = reads; done0 = done_cnt; del0 = delivered; got0 = got_q.size();
    @(negedge clk);
    start = 1'b1; base_addr = base; length = LB'(len);
    @(negedge clk);
    start = 1'b0; base_addr = XW'($urandom); length = LB'($urandom);
    check("lat_busy", 32'(busy), 32'(len != 0));
    check("lat_req_c1", 32'(mem_rd_req), 32'd0);
    check("lat_done_c1", 32'(done), 32'(len == 0));
    @(negedge clk);
    check("lat_req_c2", 32'(mem_rd_req), 32'(len != 0));
  endtask

  task automatic finish_xfer(input int len, input logic [DW-1:0] exp_first,
                             input logic [XW-1:0] exp_last);
    int n;
    n = 0;
    while (done_cnt == done0 && n < 20000) begin @(negedge clk); n++; end
    check("done_seen", 32'(done_cnt != done0), 32'd1);
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check("drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt - done0), 32'd1);
    check("read_count", 32'(reads - reads0), 32'(len));
    check("word_count", 32'(delivered - del0), 32'(len));
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(out_valid), 32'd0);
    check("req_after", 32'(mem_rd_req), 32'd0);
    if (len != 0) begin
      check("first_word", 32'(got_q[got0]), 32'(exp_first));
      check("last_addr", 32'(last_issue), 32'(exp_last));
    end
  endtask

  typedef struct {
    logic [XW-1:0] base;
    int            len;
    int            lat;
    int            ready;
    logic [DW-1:0] exp_first;
    logic [XW-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    logic [XW-1:0] b;
    int l;

    vecs[0] = '{20'h00100, 4, 5, 100, 16'hA4A5, 20'h00103};
    vecs[1] = '{20'hFFFFE, 3, 2, 100, 16'h5A5B, 20'h00000};
    vecs[2] = '{20'h12345, 0, 3, 100, 16'h0000, 20'h00000};
    vecs[3] = '{20'h0ABCD, 7, 1,  60, 16'h0E68, 20'h0ABD3};
    vecs[4] = '{20'h7FFFF, 2, 4, 100, 16'h5A5A, 20'h80000};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mem_rd_req), 32'd0);
    check("rst_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      lat_cfg = vecs[i].lat; ready_pct = vecs[i].ready;
      start_xfer(vecs[i].base, vecs[i].len);
      finish_xfer(vecs[i].len, vecs[i].exp_first, vecs[i].exp_last);
    end

    // Backpressure: a depth-4 FIFO stops fetching after four words.
    lat_cfg = 2; ready_pct = 0;
    start_xfer(20'h00200, 10);
    repeat (60) @(negedge clk);
    check("bp_reads", 32'(reads - reads0), 32'd4);
    check("bp_req", 32'(mem_rd_req), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    ready_pct = 100;
    finish_xfer(10, 16'hA7A5, 20'h00209);

    // Abort while a read is outstanding.
    lat_cfg = 6; ready_pct = 0;
    start_xfer(20'h00300, 8);
    n = 0;
    while (!((reads - reads0 >= 3) && pending) && n < 200) begin @(negedge clk); n++; end
    check("abort_setup", 32'(reads - reads0), 32'd3);
    @(negedge clk);
    abort = 1'b1;
    addr_q.delete(); exp_q.delete();
    @(negedge clk);
    abort = 1'b0;
    check("drain_req", 32'(mem_rd_req), 32'd1);
    check("drain_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req", 32'(mem_rd_req), 32'd0);
    check("abort_pending", 32'(pending), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_nodone", 32'(done_cnt - done0), 32'd0);
    ready_pct = 100;
    lat_cfg = vecs[0].lat;
    start_xfer(vecs[0].base, vecs[0].len);
    finish_xfer(vecs[0].len, vecs[0].exp_first, vecs[0].exp_last);

    // Long transfer with random out_ready and random latency, wrapping the address.
    lat_cfg = 0; ready_pct = 50;
    start_xfer(20'hFFF80, 300);
    finish_xfer(300, 16'h5A25, 20'h000AB);

    for (int i = 0; i < 4; i++) begin
      b = XW'($urandom);
      l = int'($urandom_range(1, 24));
      ready_pct = 70;
      start_xfer(b, l);
      finish_xfer(l, b[DW-1:0] ^ 16'hA5A5, b + XW'(l - 1));
    end

    // Reset during WAIT; the late completion must not load the FIFO.
    lat_cfg = 6; ready_pct = 100;
    start_xfer(20'h40000, 5);
    n = 0;
    while (!((reads - reads0 >= 2) && pending) && n < 200) begin @(negedge clk); n++; end
    check("rst_setup", 32'(pending), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_req", 32'(mem_rd_req), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_addr", 32'(mem_rd_addr), 32'd0);
    addr_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("stray_done", 32'(pending), 32'd0);
    check("stray_valid", 32'(out_valid), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    lat_cfg = 3;
    start_xfer(vecs[3].base, vecs[3].len);
    finish_xfer(vecs[3].len, vecs[3].exp_first, vecs[3].exp_last);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdram_linefetch.md
Name: sdram_linefetch

Overview:
- Sequential read prefetcher placed directly upstream of the SDRAM controller's read port.
- Given a base word address and a word count, it issues single-word reads one at a time, in order, with at most one read outstanding.
- Returned words go into a small show-ahead FIFO, which a streaming consumer (display scanout, DMA) drains through a valid/ready handshake.

Parameters:
- XWIDTH, 20, word-address width; must equal the controller's row+bank+column width.
- DWIDTH, 16, data word width.
- LENBITS, 16, width of the transfer-length field.
- FIFO_AW, 4, log2 of FIFO depth; depth = 2^FIFO_AW words.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer.
- base_addr  in  XWIDTH  first word address; sampled when start is accepted.
- length  in  LENBITS  number of words to fetch; sampled when start is accepted.
- abort  in  1  cancel the current transfer and flush the FIFO.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the final word of a transfer enters the FIFO.
- out_data  out  DWIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- mem_rd_addr  out  XWIDTH  drives the controller's rd_addr.
- mem_rd_req  out  1  drives the controller's rd_ready (read request).
- mem_rd_data  in  DWIDTH  controller's rd_data.
- mem_rd_valid  in  1  controller's rd_valid; one-cycle pulse per completed read.

Behaviour:
- Reset values: busy=0, done=0, mem_rd_req=0, mem_rd_addr=0, FIFO empty (out_valid=0), state=IDLE. out_data is don't-care while out_valid=0.
- All outputs are registered except out_data and out_valid, which are driven from the FIFO head and the occupancy counter.
- IDLE:
  - start=1 and length!=0: latch addr=base_addr and remaining=length, set busy=1, go to RUN.
  - start=1 and length=0: pulse done the next cycle; busy stays 0.
  - mem_rd_valid is ignored in IDLE, including a stray pulse from a read issued before reset.
- RUN:
  - If remaining!=0 and occupancy < 2^FIFO_AW: assert mem_rd_req=1 with mem_rd_addr=addr, go to WAIT.
  - Otherwise stay in RUN.
  - Latency: start in cycle 0 gives mem_rd_req=1 in cycle 2 (IDLE->RUN, then RUN issues).
- WAIT:
  - Hold mem_rd_req and mem_rd_addr stable until mem_rd_valid=1.
  - On the mem_rd_valid cycle: clear mem_rd_req (registered; the controller's idle gap covers the registered deassert), write mem_rd_data into the FIFO, addr<=addr+1, remaining<=remaining-1.
  - Then, if remaining-1=0: pulse done, clear busy, go to IDLE. Otherwise go to RUN.
- Address arithmetic is modulo 2^XWIDTH; the address wraps from all-ones to 0 silently.
- Only one read is outstanding at any time, so checking occupancy < depth at issue guarantees the returned word always has a free slot. Occupancy can only fall during WAIT.
- FIFO:
  - Occupancy counter is FIFO_AW+1 bits wide; read and write pointers wrap at the depth.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pop happens when out_valid and out_ready are both 1.
  - A word pushed in cycle N is visible on out_valid/out_data in cycle N+1.
- start while busy=1 is ignored.
- A new start while the FIFO still holds words from the previous transfer is allowed; the new words append.
- abort:
  - In RUN: flush the FIFO, clear busy, go to IDLE. No done pulse.
  - In WAIT: the controller cannot cancel a read, so go to DRAIN and keep mem_rd_req asserted until mem_rd_valid. On mem_rd_valid: discard the data, clear mem_rd_req, flush the FIFO, clear busy, go to IDLE. busy stays 1 throughout DRAIN.
  - In IDLE: flush the FIFO only.
  - abort has priority over start and over push.
- Reset mid-transfer returns every output to its reset value immediately (asynchronous).

Test Plan:
- Basic fetch: base_addr=0x00100, length=4, out_ready=1, memory model returns data=addr ^ 0xA5A5 with 5-cycle latency -> requests to 0x00100..0x00103 in order, out_data sequence 0xA4A5, 0xA4A4, 0xA4A7, 0xA4A6, one done pulse, busy low afterwards.
- Backpressure: FIFO_AW=2, length=10, out_ready=0 -> exactly 4 reads issued, then mem_rd_req stays 0. Raising out_ready resumes fetching; all 10 words are delivered in order with none lost or duplicated.
- Wrap and zero length: base_addr=0xFFFFE, length=3 -> addresses 0xFFFFE, 0xFFFFF, 0x00000. A separate start with length=0 -> done pulses, no request issued, busy stays 0.
- Abort in WAIT: abort while mem_rd_req=1 -> mem_rd_req is held until mem_rd_valid, the returned word is discarded, out_valid=0 afterwards, no done pulse, the next start behaves normally.
- Simultaneous push/pop at full: depth-1 words queued, one push and one pop in the same cycle -> occupancy unchanged; no overflow or underflow over 1000 cycles of random out_ready.
- Reset mid-transfer: assert rst_n=0 during WAIT -> busy=0, mem_rd_req=0, out_valid=0 at once. A late mem_rd_valid pulse after reset releases does not load the FIFO.
